alu_pipeline: RTL and testbench
===============================

// Module: alu_pipeline
// PURPOSE
//  Parametrised, pipelined N-bit ALU with valid/ready flow control and NZCV flags.
//  Operands and opcode are captured together; result and flags emerge STAGES cycles later.
//  Replaces the single-register ALU timing wrapper in the datapath and feeds results
//  to the register-file write-back and display logic. Stalls back-pressure the source.
// PARAMETERS
//  N       4  operand/result width in bits (2..32)
//  STAGES  2  pipeline register stages from operand capture to output (1..4)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  in_valid     in   1       A/B/Sel valid this cycle
//  in_ready     out  1       block accepts operands this cycle
//  A            in   N       operand A (unsigned; signed for V/N/ASR)
//  B            in   N       operand B
//  Sel          in   4       opcode
//  out_valid    out  1       Result/flags valid
//  out_ready    in   1       sink accepts Result this cycle
//  Result       out  N       ALU result
//  flags        out  4       {N,Z,C,V}
//  div_zero     out  1       qualifies Result: op 3/4 with B==0
// BEHAVIOUR
//  Reset: one clk edge with reset=1 clears all stage valids, Result=0, flags=0,
//   div_zero=0, out_valid=0; in_ready=1 the cycle after. Reset mid-stream drops all in-flight ops.
//  Transfer in: in_valid&&in_ready at edge. Transfer out: out_valid&&out_ready at edge.
//  in_ready = out_ready || !out_valid (combinational); when 0, every stage holds (global stall).
//  Latency: accepted at edge k -> out_valid at edge k+STAGES if no stall; each stall cycle adds 1.
//  Throughput 1 op/cycle; bubbles (in_valid=0) propagate as invalid stages, not collapsed.
//  Result/flags held stable while out_valid&&!out_ready.
//  Compute in stage 1; later stages are plain delay registers.
//  Ops (Sel): 0 ADD, 1 SUB (A-B), 2 MUL (low N bits), 3 DIV (unsigned A/B), 4 MOD (A%B),
//   5 AND, 6 OR, 7 XOR, 8 SHL (A<<B[log2N-1:0]), 9 SHR logical, 10 ASR, 11 NOT A,
//   12 PASS B, 13-15 reserved -> Result=0, flags Z=1 only.
//  Shift amount B mod N (only low ceil(log2 N) bits used, B>=N wraps).
//  Flags: N=Result[N-1]; Z=(Result==0); C: ADD carry-out, SUB no-borrow (A>=B),
//   SHL last bit shifted out, SHR/ASR last bit shifted out, MUL any nonzero high product bit;
//   else 0. V: ADD/SUB signed overflow; else 0.
//  DIV/MOD by zero: Result = all ones, div_zero=1, C=V=0, N/Z from Result. Else div_zero=0.
//  Simultaneous in-transfer and out-transfer in the same cycle is legal and required for full rate.
// TESTING
//  N=4,STAGES=2: reset 1 cycle -> out_valid=0, Result=0, flags=0, in_ready=1.
//  A=3,B=2 Sel=0,1,3,5,7,9 back-to-back, out_ready=1 -> Results 5,1,1,2,1,0 two cycles after each.
//  A=7,B=1 ADD -> Result=8 flags=1001 (N,V); A=2,B=3 SUB -> 15 flags=1000 (C=0 borrow).
//  A=9,B=0 DIV -> Result=15, div_zero=1; MOD same; A=4,B=5 SHL (amt 1) -> 8, C=0.
//  Stream 6 ops, out_ready low 3 cycles mid-stream -> in_ready low, no op lost/duplicated, order kept.
//  STAGES=4,N=8: reset asserted with 3 ops in flight -> none emerge; next op latency exactly 4.

Source files
------------

// File: rtl/alu_pipeline.sv
// rtl/alu_pipeline.sv - pipelined N-bit ALU with valid/ready flow control and NZCV flags
// A capture register feeds the compute stage; STAGES-1 further delay stages follow it.
module alu_pipeline #(
  parameter int N      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   Sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic [3:0]   flags,
  output logic         div_zero
);

  localparam int SW = $clog2(N);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;
  localparam logic [3:0] OP_PSB = 4'd12;

  logic         advance;
  logic         cap_v;
  logic [N-1:0] cap_a, cap_b;
  logic [3:0]   cap_sel;

  logic [N-1:0]   st_r [STAGES];
  logic [3:0]     st_f [STAGES];
  logic [STAGES-1:0] st_v, st_dz;

  logic [N-1:0]   c_res;
  logic           c_c, c_v, c_dz;
  logic [N:0]     sum, diff, shl_w, shr_w, asr_w;
  logic [2*N-1:0] prod;
  logic [SW-1:0]  amt;

  // Whole pipe moves together; any stall freezes every stage.
  assign advance   = out_ready || !out_valid;
  assign in_ready  = advance;
  assign out_valid = st_v[STAGES-1];
  assign Result    = st_r[STAGES-1];
  assign flags     = st_f[STAGES-1];
  assign div_zero  = st_dz[STAGES-1];

  always_comb begin
    amt   = cap_b[SW-1:0];
    sum   = {1'b0, cap_a} + {1'b0, cap_b};
    diff  = {1'b0, cap_a} - {1'b0, cap_b};
    prod  = {{N{1'b0}}, cap_a} * {{N{1'b0}}, cap_b};
    // Extra bit beyond the operand catches the last bit shifted out.
    shl_w = {1'b0, cap_a} << amt;
    shr_w = {cap_a, 1'b0} >> amt;
    asr_w = $signed({cap_a, 1'b0}) >>> amt;
    c_res = '0;
    c_c   = 1'b0;
    c_v   = 1'b0;
    c_dz  = 1'b0;
    case (cap_sel)
      OP_ADD: begin
        c_res = sum[N-1:0];
        c_c   = sum[N];
        c_v   = (cap_a[N-1] == cap_b[N-1]) && (sum[N-1] != cap_a[N-1]);
      end
      OP_SUB: begin
        c_res = diff[N-1:0];
        c_c   = !diff[N];
        c_v   = (cap_a[N-1] != cap_b[N-1]) && (diff[N-1] != cap_a[N-1]);
      end
      OP_MUL: begin
        c_res = prod[N-1:0];
        c_c   = |prod[2*N-1:N];
      end
      OP_DIV, OP_MOD: begin
        if (cap_b == '0) begin
          c_res = '1;
          c_dz  = 1'b1;
        end else if (cap_sel == OP_DIV) begin
          c_res = cap_a / cap_b;
        end else begin
          c_res = cap_a % cap_b;
        end
      end
      OP_AND: c_res = cap_a & cap_b;
      OP_OR:  c_res = cap_a | cap_b;
      OP_XOR: c_res = cap_a ^ cap_b;
      OP_SHL: begin
        c_res = shl_w[N-1:0];
        c_c   = shl_w[N];
      end
      OP_SHR: begin
        c_res = shr_w[N:1];
        c_c   = shr_w[0];
      end
      OP_ASR: begin
        c_res = asr_w[N:1];
        c_c   = asr_w[0];
      end
      OP_NOT: c_res = ~cap_a;
      OP_PSB: c_res = cap_b;
      default: c_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_v   <= 1'b0;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_sel <= '0;
      st_v    <= '0;
      st_dz   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        st_r[i] <= '0;
        st_f[i] <= '0;
      end
    end else if (advance) begin
      cap_v    <= in_valid;
      cap_a    <= A;
      cap_b    <= B;
      cap_sel  <= Sel;
      st_v[0]  <= cap_v;
      st_r[0]  <= c_res;
      st_f[0]  <= {c_res[N-1], c_res == '0, c_c, c_v};
      st_dz[0] <= c_dz;
      for (int i = 1; i < STAGES; i++) begin
        st_v[i]  <= st_v[i-1];
        st_r[i]  <= st_r[i-1];
        st_f[i]  <= st_f[i-1];
        st_dz[i] <= st_dz[i-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_pipeline.sv
// tb/tb_alu_pipeline.sv - directed-vector bench for alu_pipeline (N=4/STAGES=2 and N=8/STAGES=4)
module tb_alu_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, iv1, ir1, ov1, or1, dz1;
  logic [3:0] a1, b1, sel1, res1, flg1;
  logic       rst2, iv2, ir2, ov2, or2, dz2;
  logic [7:0] a2, b2, res2;
  logic [3:0] sel2, flg2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] a, b, sel, res, flg;
    logic       dz;
    bit         lat;
    int         acc;
  } op_t;

  op_t ops[$];
  op_t exp_q[$];
  op_t m_e;

  alu_pipeline #(.N(4), .STAGES(2)) dut1 (
    .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1), .Sel(sel1),
    .out_valid(ov1), .out_ready(or1), .Result(res1), .flags(flg1), .div_zero(dz1)
  );

  alu_pipeline #(.N(8), .STAGES(4)) dut2 (
    .clk(clk), .reset(rst2), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2), .Sel(sel2),
    .out_valid(ov2), .out_ready(or2), .Result(res2), .flags(flg2), .div_zero(dz2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic add_op(input logic [3:0] a, b, sel, res, flg, input logic dz, input bit lat);
    op_t e;
    e.a = a; e.b = b; e.sel = sel; e.res = res; e.flg = flg; e.dz = dz; e.lat = lat; e.acc = 0;
    ops.push_back(e);
  endtask

  // Accept-to-first-visible spans capture + STAGES registers: 3 counted edges for STAGES=2.
  always @(negedge clk) begin
    if (ov1 && or1 && !rst1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 1, 0);
      end else begin
        m_e = exp_q.pop_front();
        check_val($sformatf("res op%0d a%0d b%0d", m_e.sel, m_e.a, m_e.b), res1, m_e.res);
        check_val($sformatf("flags op%0d a%0d b%0d", m_e.sel, m_e.a, m_e.b), flg1, m_e.flg);
        check_val($sformatf("div_zero op%0d", m_e.sel), dz1, m_e.dz);
        if (m_e.lat) check_val("latency", cyc - m_e.acc, 3);
      end
    end
  end

  task automatic run_stream(input int ss, input int sl);
    int idx = 0;
    for (int c = 0; c < 200; c++) begin
      if (idx >= ops.size() && exp_q.size() == 0) break;
      or1 = !(c >= ss && c < ss + sl);
      if (idx < ops.size()) begin
        iv1 = 1'b1; a1 = ops[idx].a; b1 = ops[idx].b; sel1 = ops[idx].sel;
      end else begin
        iv1 = 1'b0;
      end
      @(negedge clk);
      if (sl > 0 && c == ss + 1) check_val("stall_in_ready", ir1, 0);
      if (iv1 && ir1) begin
        op_t e;
        e = ops[idx];
        e.acc = cyc;
        exp_q.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
    end
    iv1 = 1'b0;
    or1 = 1'b1;
    check_val("all_issued", idx, ops.size());
    check_val("all_drained", exp_q.size(), 0);
    ops.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int lat;
    rst1 = 1'b1; rst2 = 1'b1;
    iv1 = 1'b0; iv2 = 1'b0; or1 = 1'b1; or2 = 1'b1;
    a1 = '0; b1 = '0; sel1 = '0; a2 = '0; b2 = '0; sel2 = '0;
    @(posedge clk); #1;
    rst1 = 1'b0; rst2 = 1'b0;

    check_val("rst_out_valid", ov1, 0);
    check_val("rst_result", res1, 0);
    check_val("rst_flags", flg1, 0);
    check_val("rst_div_zero", dz1, 0);
    check_val("rst_in_ready", ir1, 1);
    check_val("rst2_out_valid", ov2, 0);

    // Back-to-back with A=3,B=2, then latency checked per op.
    add_op(3, 2, 0, 5,  4'b0000, 0, 1);
    add_op(3, 2, 1, 1,  4'b0010, 0, 1);
    add_op(3, 2, 3, 1,  4'b0000, 0, 1);
    add_op(3, 2, 5, 2,  4'b0000, 0, 1);
    add_op(3, 2, 7, 1,  4'b0000, 0, 1);
    add_op(3, 2, 9, 0,  4'b0110, 0, 1);
    run_stream(0, 0);

    // Edge cases streamed through a 3-cycle sink stall.
    add_op(7, 1, 0,  8,  4'b1001, 0, 0);
    add_op(2, 3, 1,  15, 4'b1000, 0, 0);
    add_op(9, 0, 3,  15, 4'b1000, 1, 0);
    add_op(9, 0, 4,  15, 4'b1000, 1, 0);
    add_op(4, 5, 8,  8,  4'b1000, 0, 0);
    add_op(5, 7, 2,  3,  4'b0010, 0, 0);
    add_op(8, 1, 10, 12, 4'b1000, 0, 0);
    add_op(5, 0, 11, 10, 4'b1000, 0, 0);
    add_op(3, 0, 12, 0,  4'b0100, 0, 0);
    add_op(3, 3, 13, 0,  4'b0100, 0, 0);
    add_op(5, 2, 6,  7,  4'b0000, 0, 0);
    add_op(9, 4, 4,  1,  4'b0000, 0, 0);
    add_op(3, 3, 1,  0,  4'b0110, 0, 0);
    add_op(8, 8, 0,  0,  4'b0111, 0, 0);
    run_stream(3, 3);

    // Wide/deep instance: reset with three ops in flight drops them.
    for (int i = 0; i < 3; i++) begin
      iv2 = 1'b1; a2 = 8'(i + 1); b2 = 8'd1; sel2 = 4'd0;
      @(posedge clk); #1;
    end
    iv2 = 1'b0;
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov2) cnt++;
    end
    check_val("flush_none_emerge", cnt, 0);
    check_val("flush_in_ready", ir2, 1);

    @(posedge clk); #1;
    iv2 = 1'b1; a2 = 8'd100; b2 = 8'd27; sel2 = 4'd0;
    @(posedge clk); #1;
    iv2 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ov2) begin
        lat = i;
        break;
      end
    end
    check_val("stages4_latency", lat, 4);
    check_val("stages4_result", res2, 127);
    check_val("stages4_flags", flg2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
